nx_fifo_rd_stage: RTL and testbench

- Read-side stage that sits directly downstream of the team's nx_fifo.
- Drives the FIFO's ren from its empty flag and captures rdata, which is combinational and zero when empty, into a 2-entry skid buffer.
- Presents a registered valid/ready stream to the consuming pipeline.
- Breaks the combinational path from consumer ready back to FIFO ren while sustaining one beat per cycle.

---
 rtl/nx_fifo_rd_stage.sv | 112 +++++++++++
 tb/tb_nx_fifo_rd_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_rd_stage.sv
// rtl/nx_fifo_rd_stage.sv - 2-entry skid read stage downstream of nx_fifo
// Optional statistics counters enabled by defining NX_FIFO_RD_STAGE_STATS_EN.
module nx_fifo_rd_stage #(
    parameter int WIDTH      = 128,
    parameter bit DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef NX_FIFO_RD_STAGE_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [31:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             run_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;
    logic             load_head_rdata;
    logic             load_head_skid;
    logic             load_skid;

    // run_q holds off the first pop until one edge after reset release
    assign fifo_ren  = run_q && !fifo_empty && !flush && (state_q != ST_TWO);
    assign push      = fifo_ren;
    assign out_valid = (state_q != ST_EMPTY);
    assign pop       = out_valid && out_ready;
    assign out_data  = head_q;
    assign occupancy = state_q;

    assign load_head_rdata = push && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop));
    assign load_skid       = push && (state_q == ST_ONE) && !pop;
    assign load_head_skid  = !flush && (state_q == ST_TWO) && pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: if (push) state_q <= ST_ONE;
                    ST_ONE: begin
                        if (push && !pop)      state_q <= ST_TWO;
                        else if (!push && pop) state_q <= ST_EMPTY;
                    end
                    ST_TWO:   if (pop) state_q <= ST_ONE;
                    default:  state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    generate
        if (DATA_RESET) begin : g_data_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    head_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_head_rdata)     head_q <= fifo_rdata;
                    else if (load_head_skid) head_q <= skid_q;
                    if (load_skid)           skid_q <= fifo_rdata;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (load_head_rdata)     head_q <= fifo_rdata;
                else if (load_head_skid) head_q <= skid_q;
                if (load_skid)           skid_q <= fifo_rdata;
            end
        end
    endgenerate

`ifdef NX_FIFO_RD_STAGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else if (flush) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (beat_count != 32'hFFFF_FFFF))
                beat_count <= beat_count + 32'd1;
            if (out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// tb/tb_nx_fifo_rd_stage.sv - directed self-checking bench for nx_fifo_rd_stage
module tb_nx_fifo_rd_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         out_ready;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_ren;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef NX_FIFO_RD_STAGE_STATS_EN
    logic [31:0]  beat_count;
    logic [31:0]  stall_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [64];
    logic [6:0]   wr_ptr = '0;
    logic [6:0]   rd_ptr = '0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = fifo_empty ? '0 : mem[rd_ptr[5:0]];

    always @(posedge clk) if (fifo_ren) rd_ptr <= rd_ptr + 7'd1;

    nx_fifo_rd_stage #(.WIDTH(W), .DATA_RESET(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef NX_FIFO_RD_STAGE_STATS_EN
        ,
        .beat_count (beat_count),
        .stall_count(stall_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 7'd1;
    endtask

    task automatic test_reset();
        push_word(32'h55);
        tick();
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", fifo_ren); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        rst_n = 1'b1;
        #1;
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_release_ren got %b exp 0", fifo_ren); end
        tick();
        checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL reset_first_ren got %b exp 1", fifo_ren); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin errors++; $display("FAIL reset_first_word got v=%b d=%h exp v=1 d=55", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_drain_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [W-1:0] exp_w [3];
        int ren_cnt;
        exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
        ren_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(exp_w[i]);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (fifo_ren) ren_cnt++;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                errors++; $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_w[i]);
            end
        end
        if (fifo_ren) ren_cnt++;
        tick();
        checks++; if (ren_cnt !== 3) begin errors++; $display("FAIL stream_ren_count got %0d exp 3", ren_cnt); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_end_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int ren_cnt;
        ren_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'h100 + i);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (fifo_ren) ren_cnt++;
            tick();
        end
        checks++; if (ren_cnt !== 2) begin errors++; $display("FAIL bp_ren_count got %0d exp 2", ren_cnt); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", occupancy); end
        checks++; if (out_data !== 32'h100) begin errors++; $display("FAIL bp_hold got %h exp 100", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 + k) begin
                errors++; $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, 32'h100 + k);
            end
            tick();
        end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bp_end_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_empty();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (fifo_ren !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL empty_idle got %0d bad cycles exp 0", bad); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL empty_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'h200 + i);
        tick();
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", occupancy); end
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL flush_ren_two got %b exp 0", fifo_ren); end
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h202) begin errors++; $display("FAIL flush_new_head got v=%b d=%h exp v=1 d=202", out_valid, out_data); end
        push_word(32'h203);
        flush = 1'b1;
        #1;
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL flush_ren_one got %b exp 0", fifo_ren); end
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h203) begin errors++; $display("FAIL flush_second_head got v=%b d=%h exp v=1 d=203", out_valid, out_data); end
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_end_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'h300 + i);
        tick();
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got %0d exp 2", occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL areset_drop got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL areset_ren got %b exp 0", fifo_ren); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL areset_release_ren got %b exp 0", fifo_ren); end
        tick();
        checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL areset_resume_ren got %b exp 1", fifo_ren); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h302) begin errors++; $display("FAIL areset_resume_data got v=%b d=%h exp v=1 d=302", out_valid, out_data); end
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL areset_end_occ got %0d exp 0", occupancy); end
        out_ready = 1'b0;
    endtask

`ifdef NX_FIFO_RD_STAGE_STATS_EN
    task automatic test_stats();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (beat_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL stats_clear0 got b=%0d s=%0d exp 0 0", beat_count, stall_count); end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h400 + i);
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        checks++; if (beat_count !== 32'd4) begin errors++; $display("FAIL stats_beats got %0d exp 4", beat_count); end
        checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL stats_stalls got %0d exp 3", stall_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (beat_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL stats_flush got b=%0d s=%0d exp 0 0", beat_count, stall_count); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_flush();
        test_async_reset();
`ifdef NX_FIFO_RD_STAGE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
